// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq: Avalon-MM input PIO with a synchroniser, per-bit edge
// detection, a sticky edge-capture register and a maskable registered IRQ.
//   clk, reset     : clock and synchronous active-high reset
//   address        : word address (0 data, 1 reserved, 2 irq mask, 3 capture)
//   chipselect     : slave select
//   write_n        : active-low write strobe
//   writedata      : write data (bits above WIDTH ignored)
//   readdata       : registered read data, one cycle latency
//   in_port        : asynchronous external inputs
//   irq            : registered interrupt request
module pio_in_edge_irq #(
  parameter int unsigned      WIDTH            = 32,
  parameter int unsigned      SYNC_STAGES      = 2,
  parameter int unsigned      EDGE_TYPE        = 0,
  parameter int unsigned      IRQ_TYPE         = 1,
  parameter int unsigned      BIT_CLEARING     = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE_MASK = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [WIDTH-1:0] w_sync_q;
  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] w_det;
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] r_mask;
  logic [2:0]       r_prime;
  logic             w_wr;
  logic [31:0]      w_rd;
  logic [31:0]      r_readdata;
  logic             r_irq;
  logic             w_unused_wd;

  assign w_wr        = chipselect & ~write_n;
  assign w_sync_q    = r_sync[SYNC_STAGES-1];
  assign readdata    = r_readdata;
  assign irq         = r_irq;
  assign w_unused_wd = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
      r_prev <= '0;
    end else begin
      r_sync[0] <= in_port;
      for (int unsigned k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
      r_prev <= w_sync_q;
    end
  end

  // Priming counter: covers the cycles in which the freshly cleared
  // synchroniser fills, so inputs already high at reset raise no edge.
  always_ff @(posedge clk) begin
    if (reset) r_prime <= 3'(SYNC_STAGES + 1);
    else if (r_prime != '0) r_prime <= r_prime - 3'd1;
  end

  always_comb begin
    w_det = '0;
    if (r_prime == '0) begin
      case (EDGE_TYPE)
        0:       w_det = w_sync_q & ~r_prev;
        1:       w_det = ~w_sync_q & r_prev;
        default: w_det = w_sync_q ^ r_prev;
      endcase
    end
  end

  always_comb begin
    w_clr = '0;
    if (w_wr && address == 2'd3) begin
      if (BIT_CLEARING != 0) w_clr = writedata[WIDTH-1:0];
      else                   w_clr = '1;
    end
  end

  // New edges OR in after the clear so a coincident clear cannot drop them.
  always_ff @(posedge clk) begin
    if (reset) r_cap <= '0;
    else       r_cap <= (r_cap & ~w_clr) | w_det;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mask <= (IRQ_TYPE != 0) ? RESET_VALUE_MASK : '0;
    end else if (IRQ_TYPE != 0 && w_wr && address == 2'd2) begin
      r_mask <= writedata[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq <= 1'b0;
    end else begin
      case (IRQ_TYPE)
        1:       r_irq <= |(r_cap & r_mask);
        2:       r_irq <= |(w_sync_q & r_mask);
        default: r_irq <= 1'b0;
      endcase
    end
  end

  always_comb begin
    w_rd = '0;
    case (address)
      2'd0:    w_rd[WIDTH-1:0] = w_sync_q;
      2'd2:    w_rd[WIDTH-1:0] = r_mask;
      2'd3:    w_rd[WIDTH-1:0] = r_cap;
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_readdata <= '0;
    else       r_readdata <= w_rd;
  end

endmodule
